// File: rtl/iomem_timer_pkg.sv
// iomem_timer_pkg: register indices, bit positions and byte-merge helper for iomem_timer
package iomem_timer_pkg;
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_PRESC  = 3'd1;
    localparam logic [2:0] REG_RELOAD = 3'd2;
    localparam logic [2:0] REG_COUNT  = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam int CTRL_EN     = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int STATUS_EXP  = 0;
    localparam logic [7:0] DEFAULT_BASE_SEL = 8'h04;

    function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [3:0] wstrb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/iomem_timer_prescaler.sv
// timer_prescaler: divides clk by presc+1, pulsing tick in the last cycle of each period
// Ports: clk, resetn (sync, active-low), en (run), clr (restart period), presc (terminal value), tick (out)
module timer_prescaler #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);
    logic [PRESC_W-1:0] pcnt;

    assign tick = en && pcnt == presc;

    always_ff @(posedge clk)
        if (!resetn || !en || clr || tick) pcnt <= '0;
        else pcnt <= pcnt + PRESC_W'(1);
endmodule

// File: rtl/iomem_timer.sv
// iomem_timer: memory-mapped 32-bit down-counting timer with prescaler, auto-reload and sticky expiry irq
// Ports: clk, resetn (sync, active-low), iomem_valid/ready/wstrb/addr/wdata/rdata (PicoSoC iomem bus), irq (level)
module iomem_timer
    import iomem_timer_pkg::*;
#(
    parameter logic [7:0] BASE_SEL = DEFAULT_BASE_SEL,
    parameter int         PRESC_W  = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);
    logic [2:0]         ctrl;
    logic [PRESC_W-1:0] presc;
    logic [31:0]        reload, count, count_next, rd_mux, wmerge;
    logic               exp, sel, wr, tick, exp_set, exp_clr;
    logic [2:0]         idx;
    logic               unused_addr;

    assign sel         = iomem_valid && !iomem_ready && iomem_addr[31:24] == BASE_SEL;
    assign wr          = sel && |iomem_wstrb;
    assign idx         = iomem_addr[4:2];
    assign irq         = exp && ctrl[CTRL_IRQ_EN];
    assign unused_addr = ^{iomem_addr[23:5], iomem_addr[1:0]};

    timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk   (clk),
        .resetn(resetn),
        .en    (ctrl[CTRL_EN]),
        .clr   (wr && (idx == REG_PRESC || idx == REG_CTRL)),
        .presc (presc),
        .tick  (tick)
    );

    // rd_mux doubles as the pre-write value for byte-strobe merging
    always_comb begin
        rd_mux = idx == REG_CTRL   ? {29'b0, ctrl} :
                 idx == REG_PRESC  ? 32'(presc) :
                 idx == REG_RELOAD ? reload :
                 idx == REG_COUNT  ? count :
                 idx == REG_STATUS ? {31'b0, exp} : 32'b0;
        wmerge = byte_merge(rd_mux, iomem_wdata, iomem_wstrb);
        exp_set = tick && count == 32'd1;
        exp_clr = wr && idx == REG_STATUS && iomem_wstrb[0] && iomem_wdata[STATUS_EXP];
        count_next = wr && idx == REG_COUNT ? wmerge :
                     !tick || count == 32'd0 ? count :
                     count == 32'd1 ? (ctrl[CTRL_AUTO] ? reload : 32'd0) : count - 32'd1;
    end

    always_ff @(posedge clk)
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            ctrl        <= '0;
            presc       <= '0;
            reload      <= '0;
            count       <= '0;
            exp         <= 1'b0;
        end else begin
            iomem_ready <= sel;
            iomem_rdata <= sel ? rd_mux : '0;
            if (wr && idx == REG_CTRL) ctrl <= wmerge[2:0];
            if (wr && idx == REG_PRESC) presc <= wmerge[PRESC_W-1:0];
            if (wr && idx == REG_RELOAD) reload <= wmerge;
            count <= count_next;
            exp   <= exp_set || (exp && !exp_clr);
        end
endmodule

// File: tb/tb_iomem_timer.sv
// tb_iomem_timer: directed scoreboard bench for iomem_timer
module tb_iomem_timer;
    import iomem_timer_pkg::*;
    localparam logic [31:0] BASE = 32'h0400_0000;

    logic        clk = 1'b0, resetn = 1'b0, iomem_valid = 1'b0;
    logic [3:0]  iomem_wstrb = 4'b0;
    logic [31:0] iomem_addr = 32'b0, iomem_wdata = 32'b0;
    logic        iomem_ready, irq;
    logic [31:0] iomem_rdata;
    int          passed = 0, total = 0;
    logic [32:0] sb[$];

    iomem_timer dut (
        .clk        (clk),
        .resetn     (resetn),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr (iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input logic [31:0] e);
        int n = 0;
        sb.push_back({s == 4'b0, e});
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wstrb = s;
        iomem_wdata = d;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!iomem_ready && n < 8);
        if (!iomem_ready) begin
            chk("bus_timeout", 32'(iomem_ready), 1);
            void'(sb.pop_back());
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0;
    endtask

    task automatic wr(input logic [2:0] i, input logic [31:0] d);
        bus(BASE | {27'b0, i, 2'b0}, 4'hf, d, 32'b0);
    endtask

    task automatic rd(input logic [2:0] i, input logic [31:0] e);
        bus(BASE | {27'b0, i, 2'b0}, 4'h0, 32'b0, e);
    endtask

    initial begin
        logic prev = 1'b0;
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (iomem_ready) begin
                chk("ready_width", 32'(prev), 0);
                if (sb.size() == 0) chk("unexpected_ready", 32'(iomem_ready), 0);
                else begin
                    e = sb.pop_front();
                    if (e[32]) chk("rdata", iomem_rdata, e[31:0]);
                end
            end
            prev = iomem_ready;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        cyc(3);
        chk("rst_ready", 32'(iomem_ready), 0);
        chk("rst_rdata", iomem_rdata, 0);
        chk("rst_irq", 32'(irq), 0);
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) rd(3'(i), 0);
        chk("idle_irq", 32'(irq), 0);

        wr(REG_PRESC, 3);
        wr(REG_COUNT, 5);
        wr(REG_CTRL, 32'b101);
        seen = 1'b0;
        repeat (19) begin
            cyc(1);
            seen |= irq;
        end
        chk("oneshot_early", 32'(seen), 0);
        cyc(1);
        chk("oneshot_irq_20", 32'(irq), 1);
        rd(REG_COUNT, 0);
        rd(REG_STATUS, 1);
        cyc(10);
        rd(REG_COUNT, 0);

        wr(REG_CTRL, 0);
        wr(REG_STATUS, 1);
        chk("clr_irq", 32'(irq), 0);
        wr(REG_PRESC, 0);
        wr(REG_RELOAD, 4);
        wr(REG_COUNT, 4);
        wr(REG_CTRL, 32'b111);
        cyc(3);
        chk("auto_pre1", 32'(irq), 0);
        cyc(1);
        chk("auto_exp1", 32'(irq), 1);
        wr(REG_STATUS, 1);
        chk("auto_clr1", 32'(irq), 0);
        cyc(2);
        chk("auto_pre2", 32'(irq), 0);
        cyc(1);
        chk("auto_exp2", 32'(irq), 1);
        wr(REG_STATUS, 1);
        chk("auto_clr2", 32'(irq), 0);
        cyc(2);
        wr(REG_STATUS, 1);
        chk("set_beats_clr", 32'(irq), 1);
        rd(REG_STATUS, 1);
        wr(REG_CTRL, 0);

        wr(REG_RELOAD, 32'h1122_3344);
        bus(BASE | 32'h8, 4'b0010, 32'h0000_AB00, 0);
        rd(REG_RELOAD, 32'h1122_AB44);

        iomem_addr  = 32'h0300_0008;
        iomem_valid = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            cyc(1);
            seen |= iomem_ready;
        end
        iomem_valid = 1'b0;
        chk("foreign_ready", 32'(seen), 0);

        wr(REG_COUNT, 100);
        wr(REG_CTRL, 32'b101);
        cyc(10);
        chk("pre_rst_irq", 32'(irq), 1);
        resetn = 1'b0;
        cyc(1);
        chk("mid_rst_irq", 32'(irq), 0);
        chk("mid_rst_ready", 32'(iomem_ready), 0);
        chk("mid_rst_rdata", iomem_rdata, 0);
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) rd(3'(i), 0);
        wr(REG_COUNT, 5);
        cyc(20);
        rd(REG_COUNT, 5);
        chk("post_rst_irq", 32'(irq), 0);

        cyc(3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
